// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one-slot fetch buffer between instruction memory and decode.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [31:0] IMemData,
   output logic [31:0] Instruction,
   output logic [5:0]  OpCode,
   output logic        InstrValid,
   output logic [31:0] PCPlus4,
   output logic [31:0] PC
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0] FetchCount,
   output logic [15:0] RedirectCount
`endif
);

   localparam logic [0:0] S_REQ  = 1'b0;
   localparam logic [0:0] S_HOLD = 1'b1;

   logic [0:0]  stateReg, stateNext;
   logic [31:0] pcReg, pcNext;
   logic [31:0] instrReg, instrNext;
   logic [31:0] pcPlus4Reg, pcPlus4Next;
   logic [31:0] pcInc;
   logic        fetch;
   logic        consume;
   logic        unusedRedirectLsb;

   // Targets are forced word-aligned, so the low bits of RedirectPC never matter.
   assign unusedRedirectLsb = ^RedirectPC[1:0];

   assign pcInc   = pcReg + 32'd4;
   assign IMemReq = Reset && !Redirect && ((stateReg == S_REQ) || !Stall);
   assign fetch   = IMemReq && IMemAck;
   assign consume = (stateReg == S_HOLD) && !Stall;

   always_comb begin
      stateNext   = stateReg;
      pcNext      = pcReg;
      instrNext   = instrReg;
      pcPlus4Next = pcPlus4Reg;
      if (Redirect) begin
         pcNext    = {RedirectPC[31:2], 2'b00};
         stateNext = S_REQ;
      end else if (fetch) begin
         // Covers both a plain fill and a consume-and-refill on the same edge.
         instrNext   = IMemData;
         pcPlus4Next = pcInc;
         pcNext      = pcInc;
         stateNext   = S_HOLD;
      end else if (consume) begin
         stateNext = S_REQ;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         stateReg   <= S_REQ;
         pcReg      <= 32'h0000_0000;
         instrReg   <= 32'h0000_0000;
         pcPlus4Reg <= 32'h0000_0000;
      end else begin
         stateReg   <= stateNext;
         pcReg      <= pcNext;
         instrReg   <= instrNext;
         pcPlus4Reg <= pcPlus4Next;
      end
   end

   assign IMemAddr    = pcReg;
   assign PC          = pcReg;
   assign Instruction = instrReg;
   assign OpCode      = instrReg[31:26];
   assign PCPlus4     = pcPlus4Reg;
   assign InstrValid  = (stateReg == S_HOLD);

`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetchCountReg;
   logic [15:0] redirectCountReg;

   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         fetchCountReg    <= 32'd0;
         redirectCountReg <= 16'd0;
      end else begin
         if (consume && (fetchCountReg != 32'hFFFF_FFFF))
            fetchCountReg <= fetchCountReg + 32'd1;
         if (Redirect && (redirectCountReg != 16'hFFFF))
            redirectCountReg <= redirectCountReg + 16'd1;
      end
   end

   assign FetchCount    = fetchCountReg;
   assign RedirectCount = redirectCountReg;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit; define IFU_PERF_CNT_EN to also check the counters.
module tb_instr_fetch_unit;

   logic        Clk;
   logic        Reset;
   logic        Stall;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemAck;
   logic [31:0] IMemData;
   logic [31:0] Instruction;
   logic [5:0]  OpCode;
   logic        InstrValid;
   logic [31:0] PCPlus4;
   logic [31:0] PC;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] FetchCount;
   logic [15:0] RedirectCount;
`endif

   int assertCount = 0;
   int failCount   = 0;

   // Reference state of the fetch unit and the presented-instruction scoreboard.
   logic [31:0] mPc;
   logic        mValid;
   logic [31:0] mFetchCnt;
   logic [15:0] mRedirCnt;
   logic [63:0] expQ[$];

   instr_fetch_unit dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
      .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
      .Instruction(Instruction), .OpCode(OpCode), .InstrValid(InstrValid),
      .PCPlus4(PCPlus4), .PC(PC)
`ifdef IFU_PERF_CNT_EN
      , .FetchCount(FetchCount), .RedirectCount(RedirectCount)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h8C22_0004;
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign IMemData = memWord(IMemAddr);

   task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      mPc       = 32'h0;
      mValid    = 1'b0;
      mFetchCnt = 32'h0;
      mRedirCnt = 16'h0;
      expQ.delete();
   endtask

   // Drive one cycle just after a falling edge, check before and after the rising edge.
   task automatic cycle(input logic rst, input logic stall, input logic redir,
                        input logic [31:0] rpc, input logic ack);
      logic        expReq;
      logic        consume;
      logic [63:0] exp;
      Reset = rst; Stall = stall; Redirect = redir; RedirectPC = rpc; IMemAck = ack;
      #1;
      expReq  = rst && !redir && (!mValid || !stall);
      consume = rst && mValid && !stall;
      checkValue("IMemReq", {31'b0, IMemReq}, {31'b0, expReq});
      checkValue("IMemAddr", IMemAddr, mPc);
      if (consume) begin
         checkValue("sbDepth", expQ.size(), 1);
         if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            checkValue("Instruction", Instruction, exp[31:0]);
            checkValue("OpCode", {26'b0, OpCode}, {26'b0, exp[31:26]});
            checkValue("PCPlus4", PCPlus4, exp[63:32]);
         end
         if (mFetchCnt != 32'hFFFF_FFFF) mFetchCnt = mFetchCnt + 32'd1;
      end
      if (!rst) begin
         modelReset();
      end else if (redir) begin
         mPc    = {rpc[31:2], 2'b00};
         mValid = 1'b0;
         expQ.delete();
         if (mRedirCnt != 16'hFFFF) mRedirCnt = mRedirCnt + 16'd1;
      end else if (expReq && ack) begin
         expQ.push_back({mPc + 32'd4, memWord(mPc)});
         mPc    = mPc + 32'd4;
         mValid = 1'b1;
      end else if (consume) begin
         mValid = 1'b0;
      end
      @(posedge Clk);
      #1;
      checkValue("InstrValid", {31'b0, InstrValid}, {31'b0, mValid});
      checkValue("PC", PC, mPc);
`ifdef IFU_PERF_CNT_EN
      checkValue("FetchCount", FetchCount, mFetchCnt);
      checkValue("RedirectCount", {16'b0, RedirectCount}, {16'b0, mRedirCnt});
`endif
      @(negedge Clk);
   endtask

   initial begin
      Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0; IMemAck = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      modelReset();

      // Reset holds everything idle even with an ack present.
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

      // Zero-latency memory, no stall: one instruction per cycle from address 0.
      repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      // Jump to 0x10 and make memory wait three cycles.
      cycle(1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b0);
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      // Hold a load instruction under a five-cycle stall with ack asserted.
      cycle(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      // Redirect beats stall and ack; the misaligned target is word-aligned.
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0403, 1'b1);
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      // Fetch at the top of the address space wraps to zero.
      cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      // Redirect while presenting and not stalled still consumes the instruction.
      cycle(1'b1, 1'b0, 1'b1, 32'h0000_2000, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      // Randomised traffic.
      for (int i = 0; i < 60; i++) begin
         cycle(1'b1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
               $urandom, ($urandom_range(0, 2) != 0));
      end

      // Reset in the middle of a hold with ack present, then restart.
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
